// File: rtl/top_multi_engine_pkg.sv
// top_multi_engine_pkg: run-FSM state type, engine control codes and a width helper
// shared by the N-engine convolution top and its sub-modules.
package top_multi_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_RUN  = 2'b01;
    localparam logic [1:0] CTRL_LAST = 2'b11;

    // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/eng_sum_tree.sv
// eng_sum_tree: registered masked sum of NUM_ENG engine outputs into ACC_W bits.
// Build option TOP_MULTI_ENGINE_SAT_EN clamps each sum to 2**DATA_W-1.
module eng_sum_tree #(
    parameter int NUM_ENG = 4,
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic [NUM_ENG-1:0]        mask_i,
    input  logic [NUM_ENG*DATA_W-1:0] a_i,
    input  logic [NUM_ENG*DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]          sum_a_o,
    output logic [ACC_W-1:0]          sum_b_o
);
`ifdef TOP_MULTI_ENGINE_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({DATA_W{1'b1}});
`endif

    logic [ACC_W-1:0] sum_a_d, sum_b_d, sum_a_q, sum_b_q;

    // Add the selected lanes, clamping in the saturating build.
    always_comb begin
        sum_a_d = '0;
        sum_b_d = '0;
        for (int e = 0; e < NUM_ENG; e++) begin
            if (mask_i[e]) begin
                sum_a_d = sum_a_d + ACC_W'(a_i[e*DATA_W +: DATA_W]);
                sum_b_d = sum_b_d + ACC_W'(b_i[e*DATA_W +: DATA_W]);
            end
        end
`ifdef TOP_MULTI_ENGINE_SAT_EN
        if (sum_a_d > SAT_MAX) sum_a_d = SAT_MAX;
        if (sum_b_d > SAT_MAX) sum_b_d = SAT_MAX;
`endif
    end

    // Capture the sums once per run and hold them for the output port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_a_q <= '0;
            sum_b_q <= '0;
        end else if (load_i) begin
            sum_a_q <= sum_a_d;
            sum_b_q <= sum_b_d;
        end
    end

    assign sum_a_o = sum_a_q;
    assign sum_b_o = sum_b_q;

endmodule

// File: rtl/engine_3x3_2_2.sv
// engine_3x3_2_2: streaming dot-product engine. Each valid feature word (bytes f[k])
// adds sum f[k]*w[k] to outa and sum f[k]*w[k+1] to outb, saturating at the
// DATA_W range. The first valid word of a run restarts both accumulators.
// Results appear two cycles after the word tagged CTRL_LAST and then hold.
module engine_3x3_2_2
    import top_multi_engine_pkg::*;
#(
    parameter int FIN_W  = 64,
    parameter int WGT_W  = 72,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FIN_W-1:0]  fin,
    input  logic [WGT_W-1:0]  weights,
    input  logic [1:0]        control,
    input  logic              v_flag,
    output logic [DATA_W-1:0] outa,
    output logic [DATA_W-1:0] outb
);
    localparam int NB = FIN_W / 8;
    localparam int PW = 16 + clog2(NB) + 1;
    localparam int SW = ((PW > DATA_W) ? PW : DATA_W) + 1;
    localparam logic [SW-1:0] MAXV = SW'({DATA_W{1'b1}});

    logic [PW-1:0]     dot_a, dot_b;
    logic [SW-1:0]     sum_a, sum_b;
    logic [DATA_W-1:0] base_a, base_b, acc_a_q, acc_b_q, nxt_a, nxt_b;
    logic              acc_en, first, v_q, last_q;

    assign acc_en = v_flag && control[0];
    assign first  = acc_en && !v_q;

    // Per-word dot products against two weight windows offset by one byte.
    always_comb begin
        dot_a = '0;
        dot_b = '0;
        for (int k = 0; k < NB; k++) begin
            dot_a = dot_a + PW'(fin[8*k +: 8]) * PW'(weights[8*k +: 8]);
            dot_b = dot_b + PW'(fin[8*k +: 8]) * PW'(weights[8*k+8 +: 8]);
        end
    end

    // Saturating accumulate.
    always_comb begin
        base_a = first ? '0 : acc_a_q;
        base_b = first ? '0 : acc_b_q;
        sum_a  = SW'(base_a) + SW'(dot_a);
        sum_b  = SW'(base_b) + SW'(dot_b);
        nxt_a  = (sum_a > MAXV) ? {DATA_W{1'b1}} : sum_a[DATA_W-1:0];
        nxt_b  = (sum_b > MAXV) ? {DATA_W{1'b1}} : sum_b[DATA_W-1:0];
    end

    // Accumulators, then one pipeline stage into the held result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= 1'b0;
            last_q  <= 1'b0;
            acc_a_q <= '0;
            acc_b_q <= '0;
            outa    <= '0;
            outb    <= '0;
        end else begin
            v_q    <= acc_en;
            last_q <= acc_en && (control == CTRL_LAST);
            if (acc_en) begin
                acc_a_q <= nxt_a;
                acc_b_q <= nxt_b;
            end
            if (last_q) begin
                outa <= acc_a_q;
                outb <= acc_b_q;
            end
        end
    end

endmodule

// File: rtl/top_multi_engine.sv
// top_multi_engine: one feature buffer broadcast to NUM_ENG engines with private
// weights; masked sums returned on a valid/ready port.
// Build option TOP_MULTI_ENGINE_SAT_EN: sums clamp to 2**DATA_W-1.
//
// state | meaning
// IDLE  | buffer/weight loads accepted, waiting for start
// RUN   | streaming buffer words 0..DEPTH-1 into the engines
// DRAIN | waiting out engine latency, sums captured on the last cycle
// OUT   | result offered until out_ready
module top_multi_engine
    import top_multi_engine_pkg::*;
#(
    parameter int  NUM_ENG = 4,
    parameter int  DATA_W  = 16,
    parameter int  FIN_W   = 64,
    parameter int  WGT_W   = 72,
    parameter int  ADDR_W  = 3,
    parameter int  ENG_LAT = 2,
    localparam int ACC_W   = DATA_W + $clog2(NUM_ENG),
    // One spare code point so an out-of-range engine select can be presented.
    localparam int SEL_W   = clog2(NUM_ENG + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_we,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [FIN_W-1:0]   in_data,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [SEL_W-1:0]   w_sel,
    input  logic [WGT_W-1:0]   w_data,
    input  logic [NUM_ENG-1:0] eng_mask,
    input  logic               start,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   outa,
    output logic [ACC_W-1:0]   outb,
    output logic               err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CTR_W = clog2(ENG_LAT + 1);

    state_t                    state_q, state_d;
    logic [FIN_W-1:0]          buf_q [DEPTH];
    logic [WGT_W-1:0]          wreg_q [NUM_ENG];
    logic [ADDR_W-1:0]         rd_ptr_q;
    logic [CTR_W-1:0]          ctr_q;
    logic [NUM_ENG-1:0]        mask_q;
    logic                      err_q, err_d;
    logic [1:0]                ctrl;
    logic                      v_flag, last_word, sum_load, w_fire;
    logic [NUM_ENG*DATA_W-1:0] eng_a, eng_b;

    assign last_word = (rd_ptr_q == ADDR_W'(DEPTH - 1));
    assign sum_load  = (state_q == DRAIN) && (ctr_q == CTR_W'(1));
    assign w_fire    = w_valid && w_ready;
    assign err       = err_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)           state_d = RUN;
            RUN:     if (last_word)       state_d = DRAIN;
            DRAIN:   if (ctr_q == CTR_W'(1)) state_d = OUT;
            OUT:     if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Moore outputs and engine control.
    always_comb begin
        ctrl      = CTRL_IDLE;
        v_flag    = 1'b0;
        busy      = (state_q != IDLE);
        w_ready   = (state_q == IDLE);
        out_valid = (state_q == OUT);
        if (state_q == RUN) begin
            v_flag = 1'b1;
            ctrl   = last_word ? CTRL_LAST : CTRL_RUN;
        end
    end

    // Sticky error: traffic outside IDLE or a weight aimed past the last engine.
    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && start) err_d = 1'b0;
        if ((state_q != IDLE) && (in_we || w_valid)) err_d = 1'b1;
        if (w_fire && (w_sel >= SEL_W'(NUM_ENG))) err_d = 1'b1;
    end

    // Read pointer, drain counter, latched mask and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            ctr_q    <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: if (start) begin
                    rd_ptr_q <= '0;
                    mask_q   <= eng_mask;
                end
                RUN: begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    if (last_word) ctr_q <= CTR_W'(ENG_LAT);
                end
                DRAIN:   ctr_q <= ctr_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Feature buffer; contents survive reset.
    always_ff @(posedge clk) begin
        if (in_we && (state_q == IDLE)) buf_q[in_addr] <= in_data;
    end

    // Per-engine weight registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENG; e++) wreg_q[e] <= '0;
        end else if (w_fire) begin
            for (int e = 0; e < NUM_ENG; e++) begin
                if (w_sel == SEL_W'(e)) wreg_q[e] <= w_data;
            end
        end
    end

    for (genvar e = 0; e < NUM_ENG; e++) begin : g_eng
        engine_3x3_2_2 #(
            .FIN_W  (FIN_W),
            .WGT_W  (WGT_W),
            .DATA_W (DATA_W)
        ) u_eng (
            .clk     (clk),
            .rst     (rst),
            .fin     (buf_q[rd_ptr_q]),
            .weights (wreg_q[e]),
            .control (ctrl),
            .v_flag  (v_flag),
            .outa    (eng_a[e*DATA_W +: DATA_W]),
            .outb    (eng_b[e*DATA_W +: DATA_W])
        );
    end

    eng_sum_tree #(
        .NUM_ENG (NUM_ENG),
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W)
    ) u_sum (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sum_load),
        .mask_i  (mask_q),
        .a_i     (eng_a),
        .b_i     (eng_b),
        .sum_a_o (outa),
        .sum_b_o (outb)
    );

endmodule

// File: tb/tb_top_multi_engine.sv
// tb_top_multi_engine: randomized runs of top_multi_engine against a transaction-level
// model; checks the saturating build when TOP_MULTI_ENGINE_SAT_EN is defined.
module tb_top_multi_engine;
    localparam int NUM_ENG = 4;
    localparam int DEPTH   = 8;
    localparam int LAT     = 11;
`ifdef TOP_MULTI_ENGINE_SAT_EN
    localparam logic [63:0] SAT_EXP = 64'hFFFF;
`else
    localparam logic [63:0] SAT_EXP = 64'h3FFFC;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_we = 1'b0;
    logic [2:0]  in_addr = '0;
    logic [63:0] in_data = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [2:0]  w_sel = '0;
    logic [71:0] w_data = '0;
    logic [3:0]  eng_mask = '0;
    logic        start = 1'b0;
    logic        busy, out_valid, err;
    logic        out_ready = 1'b0;
    logic [17:0] outa, outb;

    int checks = 0;
    int errors = 0;

    logic [63:0] mbuf [DEPTH];
    logic [71:0] mw [NUM_ENG];
    int          m_k = 0;
    logic        m_err = 1'b0;
    logic        m_idle, m_nerr;
    longint      m_exp_a = 0, m_exp_b = 0;

    logic [63:0] tb_words [DEPTH];
    logic [71:0] tb_w [NUM_ENG];
    int          bc;
    logic [63:0] got_a, got_b;

    always #5 clk = ~clk;

    top_multi_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_we     (in_we),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_sel     (w_sel),
        .w_data    (w_data),
        .eng_mask  (eng_mask),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outa      (outa),
        .outb      (outb),
        .err       (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Whole-run result straight from the arithmetic definition of the engines.
    function automatic void model_run(input logic [3:0] mask, output longint sa, output longint sb);
        longint ea, eb, pa, pb;
        logic [63:0] f;
        logic [71:0] w;
        sa = 0;
        sb = 0;
        for (int e = 0; e < NUM_ENG; e++) begin
            ea = 0;
            eb = 0;
            w  = mw[e];
            for (int j = 0; j < DEPTH; j++) begin
                f  = mbuf[j];
                pa = 0;
                pb = 0;
                for (int k = 0; k < 8; k++) begin
                    pa += longint'(f[8*k +: 8]) * longint'(w[8*k +: 8]);
                    pb += longint'(f[8*k +: 8]) * longint'(w[8*k+8 +: 8]);
                end
                ea = (ea + pa > 65535) ? 65535 : ea + pa;
                eb = (eb + pb > 65535) ? 65535 : eb + pb;
            end
            if (mask[e]) begin
                sa += ea;
                sb += eb;
            end
        end
`ifdef TOP_MULTI_ENGINE_SAT_EN
        if (sa > 65535) sa = 65535;
        if (sb > 65535) sb = 65535;
`endif
    endfunction

    // Model: m_k counts cycles since start (0 = idle, LAT = result offered).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k   = 0;
            m_err = 1'b0;
            for (int e = 0; e < NUM_ENG; e++) mw[e] = '0;
        end else begin
            m_idle = (m_k == 0);
            m_nerr = m_err;
            if (m_idle && start) m_nerr = 1'b0;
            if (!m_idle && (in_we || w_valid)) m_nerr = 1'b1;
            if (m_idle && in_we) mbuf[in_addr] = in_data;
            if (m_idle && w_valid) begin
                if (int'(w_sel) < NUM_ENG) mw[w_sel[1:0]] = w_data;
                else m_nerr = 1'b1;
            end
            m_err = m_nerr;
            if (m_idle) begin
                if (start) begin
                    model_run(eng_mask, m_exp_a, m_exp_b);
                    m_k = 1;
                end
            end else if (m_k < LAT) begin
                m_k++;
            end else if (out_ready) begin
                m_k = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_outa", 64'(outa), 64'd0);
            chk("rst_outb", 64'(outb), 64'd0);
            chk("rst_err", 64'(err), 64'd0);
        end else begin
            chk("busy", 64'(busy), 64'(m_k != 0));
            chk("w_ready", 64'(w_ready), 64'(m_k == 0));
            chk("out_valid", 64'(out_valid), 64'(m_k == LAT));
            chk("err", 64'(err), 64'(m_err));
            if (m_k == LAT) begin
                chk("outa", 64'(outa), 64'(m_exp_a));
                chk("outb", 64'(outb), 64'(m_exp_b));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] rnd72(input bit full);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[8*k +: 8] = full ? 8'($urandom) : 8'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic load_weights();
        for (int e = 0; e < NUM_ENG; e++) begin
            w_valid = 1'b1;
            w_sel   = 3'(e);
            w_data  = tb_w[e];
            @(negedge clk);
        end
        w_valid = 1'b0;
    endtask

    task automatic fill_buf();
        for (int j = 0; j < DEPTH; j++) begin
            in_we   = 1'b1;
            in_addr = 3'(j);
            in_data = tb_words[j];
            @(negedge clk);
        end
        in_we = 1'b0;
    endtask

    // mode 0: ready at once, 1: hold off 5 cycles, 2: random ready.
    // inject >= 0: illegal write/start/weight during the run at that cycle.
    task automatic run_once(input logic [3:0] mask, input int mode, input int inject,
                            output int busy_cnt, output logic [63:0] ra, output logic [63:0] rb);
        int n;
        eng_mask = mask;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        eng_mask = 4'($urandom);
        busy_cnt = 0;
        n = 0;
        while (!out_valid && n < 40) begin
            if (n == inject) begin
                in_we   = 1'b1;
                in_addr = 3'($urandom);
                in_data = {$urandom, $urandom};
                start   = 1'b1;
                w_valid = 1'b1;
                w_sel   = 3'd0;
                w_data  = rnd72(1'b1);
            end else begin
                in_we   = 1'b0;
                start   = 1'b0;
                w_valid = 1'b0;
            end
            busy_cnt += int'(busy);
            @(negedge clk);
            n++;
        end
        in_we   = 1'b0;
        start   = 1'b0;
        w_valid = 1'b0;
        chk("result_timeout", 64'(out_valid), 64'd1);
        ra = 64'(outa);
        rb = 64'(outb);
        n = 0;
        while (out_valid && n < 40) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (n >= 5) : 1'($urandom_range(0, 1));
            busy_cnt += int'(busy);
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        chk("handshake_timeout", 64'(out_valid), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outa", 64'(outa), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_w_ready", 64'(w_ready), 64'd1);

        // weight loads with w_valid held, then an out-of-range select
        for (int e = 0; e < NUM_ENG; e++) tb_w[e] = rnd72(1'b0);
        load_weights();
        w_valid = 1'b1;
        w_sel   = 3'(NUM_ENG);
        w_data  = {72{1'b1}};
        @(negedge clk);
        w_valid = 1'b0;
        chk("bad_sel_err", 64'(err), 64'd1);

        // hand case: word0 = 3, eng0 w = {7,5}, eng2 w = {0,2}, mask 0101
        tb_w[0] = 72'h0705;
        tb_w[2] = 72'h02;
        load_weights();
        for (int j = 0; j < DEPTH; j++) tb_words[j] = '0;
        tb_words[0] = 64'h3;
        fill_buf();
        run_once(4'b0101, 0, -1, bc, got_a, got_b);
        chk("hand_outa", got_a, 64'd21);
        chk("hand_outb", got_b, 64'd21);
        chk("hand_busy_cycles", 64'(bc), 64'd11);
        chk("start_clears_err", 64'(err), 64'd0);

        run_once(4'b0000, 0, -1, bc, got_a, got_b);
        chk("mask0_outa", got_a, 64'd0);

        run_once(4'b1111, 1, -1, bc, got_a, got_b);
        chk("bp_busy_cycles", 64'(bc), 64'd16);

        for (int it = 0; it < 20; it++) begin
            for (int e = 0; e < NUM_ENG; e++) tb_w[e] = rnd72(it % 4 == 3);
            load_weights();
            for (int j = 0; j < DEPTH; j++) tb_words[j] = 64'(rnd72(it % 5 == 4));
            fill_buf();
            run_once(4'($urandom), $urandom_range(0, 2), -1, bc, got_a, got_b);
        end

        // saturation: every engine pinned at 16'hFFFF
        for (int e = 0; e < NUM_ENG; e++) tb_w[e] = {72{1'b1}};
        load_weights();
        for (int j = 0; j < DEPTH; j++) tb_words[j] = {64{1'b1}};
        fill_buf();
        run_once(4'b1111, 0, -1, bc, got_a, got_b);
        chk("sat_outa", got_a, SAT_EXP);
        chk("sat_outb", got_b, SAT_EXP);

        // abort mid-RUN, then a clean run
        for (int e = 0; e < NUM_ENG; e++) tb_w[e] = rnd72(1'b0);
        load_weights();
        for (int j = 0; j < DEPTH; j++) tb_words[j] = 64'(rnd72(1'b0));
        fill_buf();
        eng_mask = 4'b1111;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_outa", 64'(outa), 64'd0);
        chk("abort_outb", 64'(outb), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        load_weights();
        run_once(4'b1011, 0, -1, bc, got_a, got_b);

        // illegal traffic during RUN, then a start that clears err
        for (int j = 0; j < DEPTH; j++) tb_words[j] = 64'(rnd72(1'b0));
        fill_buf();
        run_once(4'b1111, 0, 3, bc, got_a, got_b);
        chk("illegal_err", 64'(err), 64'd1);
        chk("illegal_busy_cycles", 64'(bc), 64'd11);
        run_once(4'b0110, 2, -1, bc, got_a, got_b);
        chk("err_cleared_again", 64'(err), 64'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
